amm_rr_arbiter: RTL and testbench
=================================

Name: amm_rr_arbiter

Overview:
- Parametrised N-to-1 Avalon-MM arbiter. Connects CH_NUM burst-capable slave-side ports, driven by traffic-generator channels, to one Avalon-MM master port toward the memory controller.
- Arbitration is round-robin. A write burst is locked until its last beat.
- Read commands are tagged so that pipelined readdatavalid beats are routed back to the issuing channel in order.

Parameters:
- CH_NUM, 4, number of slave-side channels (>=2).
- ADDR_W, 32, address width.
- DATA_W, 64, data width (multiple of 8).
- BURST_W, 11, burstcount width.
- TAG_DEPTH, 8, outstanding read commands tracked (power of 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_address  in  CH_NUM*ADDR_W  per-channel address; channel i occupies slice i.
- s_read  in  CH_NUM  per-channel read request.
- s_write  in  CH_NUM  per-channel write request.
- s_byteenable  in  CH_NUM*DATA_W/8  per-channel byteenable.
- s_burstcount  in  CH_NUM*BURST_W  per-channel burstcount.
- s_writedata  in  CH_NUM*DATA_W  per-channel write data.
- s_waitrequest  out  CH_NUM  per-channel stall.
- s_readdatavalid  out  CH_NUM  per-channel read beat valid.
- s_readdata  out  DATA_W  read data, broadcast to all channels.
- m_address  out  ADDR_W  master address.
- m_read  out  1  master read.
- m_write  out  1  master write.
- m_byteenable  out  DATA_W/8  master byteenable.
- m_burstcount  out  BURST_W  master burstcount.
- m_writedata  out  DATA_W  master write data.
- m_waitrequest  in  1  master stall.
- m_readdatavalid  in  1  master read beat valid.
- m_readdata  in  DATA_W  master read data.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; last_grant=CH_NUM-1, so ch0 wins first; tag FIFO empty; beat counters 0.
  - Outputs under reset: m_read=m_write=0, s_waitrequest all 1, s_readdatavalid all 0.
- Reset mid-burst or with reads outstanding: all state dropped. Late m_readdatavalid beats arriving with an empty FIFO are discarded (no s_readdatavalid).
- Eligibility: channel i is eligible if s_write[i]=1, or if s_read[i]=1 and the tag FIFO is not full. Eligibility never looks at m_waitrequest.
- IDLE: if any channel is eligible, pick the first eligible one scanning from last_grant+1 upward, wrapping at CH_NUM. Register grant_id and go to CMD. This costs a fixed 1-cycle arbitration bubble per command.
- CMD: the granted channel's address, read, write, byteenable, burstcount and writedata are muxed to m_*.
  - s_waitrequest[grant_id] = m_waitrequest; all other s_waitrequest = 1.
  - Read accepted (m_read & !m_waitrequest): push {grant_id, burstcount} to the tag FIFO; last_grant=grant_id; go to IDLE.
  - Write accepted with burstcount<=1: last_grant=grant_id; go to IDLE.
  - Write accepted with burstcount>1: wr_left=burstcount-1; go to WR_BURST.
  - burstcount=0 is treated as 1.
- WR_BURST: grant is held. m_write=s_write[grant_id], with data and byteenable from the granted channel.
  - m_address and m_burstcount hold the values latched at the first beat.
  - Each accepted beat decrements wr_left. On the accepted beat with wr_left=1, set last_grant=grant_id and go to IDLE.
  - s_write deasserted mid-burst stalls the burst; it is never aborted.
- Read response: on m_readdatavalid, assert s_readdatavalid[head.id] in the same cycle (combinational); s_readdata=m_readdata.
  - rd_left is loaded from head.burstcount on the first beat of each command. When the last beat of a command is seen, pop the FIFO.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Tag FIFO full: read-only requesters are not granted. Write requesters are still served.
- A read and a write from the same channel asserted together is illegal; read takes precedence.
- Only read commands are tracked, so at most TAG_DEPTH read commands are outstanding at the master port.

Test Plan:
- Single read: ch2 read, addr 0x100, burstcount 4 → m_read seen 1 cycle after request; 4 m_readdatavalid beats → s_readdatavalid[2] pulses 4 times, other channels stay 0.
- Fairness: ch0..ch3 each issue a continuous stream of single writes → grant order 0,1,2,3,0,1,…; no channel is granted twice within any 4 consecutive grants.
- Burst lock: ch1 write burstcount 8 with m_waitrequest toggled every other cycle, ch0 requesting throughout → all 8 ch1 beats complete before ch0 is granted; m_address stays constant.
- Out-of-channel read return: ch3 read bl=2, then ch0 read bl=3 → 5 returned beats routed 3,3,0,0,0; FIFO empty afterwards.
- FIFO full: TAG_DEPTH=8, 8 reads outstanding plus a ninth pending read on ch1 and a write on ch2 → ch2 write is granted, ch1 read waits; the ninth read issues after the first pop.
- Reset mid-burst: rst_n low during beat 3 of 8 → next cycle m_write=0, all s_waitrequest=1, state IDLE; the first grant after reset goes to ch0.

Source files
------------

// File: rtl/amm_rr_arbiter_if.sv
// Avalon-MM bundle shared by the arbiter's two sides.
//   N = number of packed ports carried (CH_NUM on the channel side, 1 on the
//   memory side). Per-port fields sit in slice i of each vector; readdata is
//   a single shared bus.
//   master : drives the command (address/read/write/byteenable/burstcount/
//            writedata) and receives waitrequest/readdatavalid/readdata.
//   slave  : the opposite view.
interface amm_rr_arbiter_if #(
  parameter int N       = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 11
);
  logic [N*ADDR_W-1:0]   address;
  logic [N-1:0]          read;
  logic [N-1:0]          write;
  logic [N*DATA_W/8-1:0] byteenable;
  logic [N*BURST_W-1:0]  burstcount;
  logic [N*DATA_W-1:0]   writedata;
  logic [N-1:0]          waitrequest;
  logic [N-1:0]          readdatavalid;
  logic [DATA_W-1:0]     readdata;

  modport master (output address, read, write, byteenable, burstcount, writedata,
                  input  waitrequest, readdatavalid, readdata);
  modport slave  (input  address, read, write, byteenable, burstcount, writedata,
                  output waitrequest, readdatavalid, readdata);
endinterface

// File: rtl/amm_rr_arbiter.sv
// CH_NUM-to-1 Avalon-MM round-robin arbiter with write-burst locking and
// in-order routing of pipelined read data back to the issuing channel.
//   clk, rst_n : clock, synchronous active-low reset
//   s (slave)  : CH_NUM channel ports (traffic generators)
//   m (master) : single port toward the memory controller
module amm_rr_arbiter #(
  parameter int CH_NUM    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_W   = 11,
  parameter int TAG_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  amm_rr_arbiter_if.slave  s,
  amm_rr_arbiter_if.master m
);
  localparam int BE_W = DATA_W/8;
  localparam int CW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int NW   = $clog2(TAG_DEPTH+1);

  typedef enum logic [1:0] {IDLE, CMD, WR_BURST} state_t;
  typedef struct packed {
    logic [CW-1:0]      id;
    logic [BURST_W-1:0] bc;
  } tag_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_last, r_gnt, w_pick;
  logic [BURST_W-1:0] r_wr_left, r_bc, r_rd_left;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_rd_busy;
  tag_t               r_fifo [TAG_DEPTH];
  logic [PW-1:0]      r_wp, r_rp;
  logic [NW-1:0]      r_cnt;

  logic [CH_NUM-1:0]  w_elig;
  logic               w_any, w_full, w_empty;
  logic [ADDR_W-1:0]  w_g_addr;
  logic [BE_W-1:0]    w_g_be;
  logic [BURST_W-1:0] w_g_bc, w_g_bc_eff, w_head_bc_eff;
  logic [DATA_W-1:0]  w_g_wd;
  logic               w_g_read, w_g_write;
  logic               w_m_read, w_m_write, w_rd_acc, w_wr_acc, w_done;
  logic               w_rvalid, w_last_beat, w_push, w_pop;
  tag_t               w_head;

  assign w_full  = (r_cnt == NW'(TAG_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_elig  = s.write | (s.read & {CH_NUM{~w_full}});

  // Round-robin scan starting just after the last completed grant.
  always_comb begin
    int idx;
    idx    = 0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx = (int'(r_last) + k) % CH_NUM;
      if (!w_any && w_elig[idx]) begin
        w_any  = 1'b1;
        w_pick = CW'(idx);
      end
    end
  end

  assign w_g_addr   = s.address[int'(r_gnt)*ADDR_W +: ADDR_W];
  assign w_g_be     = s.byteenable[int'(r_gnt)*BE_W +: BE_W];
  assign w_g_bc     = s.burstcount[int'(r_gnt)*BURST_W +: BURST_W];
  assign w_g_wd     = s.writedata[int'(r_gnt)*DATA_W +: DATA_W];
  assign w_g_read   = s.read[r_gnt];
  assign w_g_write  = s.write[r_gnt];
  assign w_g_bc_eff = (w_g_bc == '0) ? BURST_W'(1) : w_g_bc;

  assign w_rd_acc = w_m_read  & ~m.waitrequest[0];
  assign w_wr_acc = w_m_write & ~m.waitrequest[0];
  // Grant is released (last_grant updated) on these accepted beats.
  assign w_done   = w_rd_acc
                  | (w_wr_acc && r_state == CMD && w_g_bc_eff <= BURST_W'(1))
                  | (w_wr_acc && r_state == WR_BURST && r_wr_left == BURST_W'(1));

  // Read return path: head tag names the destination channel.
  assign w_head        = r_fifo[r_rp];
  assign w_head_bc_eff = (w_head.bc == '0) ? BURST_W'(1) : w_head.bc;
  assign w_rvalid      = rst_n & m.readdatavalid[0] & ~w_empty;
  assign w_last_beat   = r_rd_busy ? (r_rd_left == BURST_W'(1))
                                   : (w_head_bc_eff == BURST_W'(1));
  assign w_push        = w_rd_acc;
  assign w_pop         = w_rvalid & w_last_beat;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_any) w_state_nxt = CMD;
      CMD:      if (w_rd_acc) w_state_nxt = IDLE;
                else if (w_wr_acc) w_state_nxt = (w_g_bc_eff > BURST_W'(1)) ? WR_BURST : IDLE;
      WR_BURST: if (w_done) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Command fields follow the granted channel; in a burst the
  // address/burstcount stay at the first-beat values.
  always_comb begin
    w_m_read      = 1'b0;
    w_m_write     = 1'b0;
    m.address     = w_g_addr;
    m.byteenable  = w_g_be;
    m.burstcount  = w_g_bc;
    m.writedata   = w_g_wd;
    s.waitrequest = '1;
    case (r_state)
      CMD: begin
        // read wins over a simultaneous write; never push into a full FIFO
        w_m_read  = w_g_read & ~w_full;
        w_m_write = w_g_write & ~w_g_read;
        s.waitrequest[r_gnt] = m.waitrequest[0];
      end
      WR_BURST: begin
        w_m_write    = w_g_write;
        m.address    = r_addr;
        m.burstcount = r_bc;
        s.waitrequest[r_gnt] = m.waitrequest[0];
      end
      default: ;
    endcase
    if (!rst_n) begin
      w_m_read      = 1'b0;
      w_m_write     = 1'b0;
      s.waitrequest = '1;
    end
  end

  assign m.read[0]  = w_m_read;
  assign m.write[0] = w_m_write;
  assign s.readdata = m.readdata;

  always_comb begin
    s.readdatavalid = '0;
    if (w_rvalid) s.readdatavalid[w_head.id] = 1'b1;
  end

  // Grant bookkeeping, burst counter, tag FIFO pointers, read beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last    <= CW'(CH_NUM-1);
      r_gnt     <= '0;
      r_wr_left <= '0;
      r_addr    <= '0;
      r_bc      <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_rd_left <= '0;
      r_rd_busy <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) r_gnt <= w_pick;
      if (w_done) r_last <= r_gnt;
      if (r_state == CMD && w_wr_acc && !w_done) begin
        r_wr_left <= w_g_bc_eff - 1'b1;
        r_addr    <= w_g_addr;
        r_bc      <= w_g_bc;
      end else if (r_state == WR_BURST && w_wr_acc) begin
        r_wr_left <= r_wr_left - 1'b1;
      end
      if (w_push) r_wp <= (r_wp == PW'(TAG_DEPTH-1)) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == PW'(TAG_DEPTH-1)) ? '0 : r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (w_rvalid) begin
        if (w_pop) r_rd_busy <= 1'b0;
        else begin
          r_rd_busy <= 1'b1;
          r_rd_left <= (r_rd_busy ? r_rd_left : w_head_bc_eff) - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= '{id: r_gnt, bc: w_g_bc};
  end
endmodule

// File: tb/tb_amm_rr_arbiter.sv
module tb_amm_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  amm_rr_arbiter_if #(.N(4), .ADDR_W(32), .DATA_W(64), .BURST_W(11)) s_if ();
  amm_rr_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(64), .BURST_W(11)) m_if ();

  amm_rr_arbiter #(.CH_NUM(4), .ADDR_W(32), .DATA_W(64), .BURST_W(11), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .s(s_if), .m(m_if));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] rd;
    logic [3:0] wr;
    int         g;
    logic       exp_rd;
    logic       exp_wr;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int i, input logic [31:0] a, input logic [10:0] bc);
    s_if.address[i*32 +: 32]    = a;
    s_if.burstcount[i*11 +: 11] = bc;
  endtask

  function automatic logic [3:0] wr_mask(input int g);
    logic [3:0] r;
    r = 4'b1111;
    r[g] = 1'b0;
    return r;
  endfunction

  function automatic int gnt_of(input logic [3:0] w);
    int r;
    r = 7;
    for (int i = 3; i >= 0; i--) if (!w[i]) r = i;
    return r;
  endfunction

  initial begin
    int n, c, beats, bad, early, g;
    logic found;
    logic [3:0] rexp [5];
    int fexp [8];

    //         rd       wr       g  rd wr
    tbl[0]  = '{4'b0000, 4'b1111, 0, 0, 1};
    tbl[1]  = '{4'b0000, 4'b1111, 1, 0, 1};
    tbl[2]  = '{4'b0000, 4'b1111, 2, 0, 1};
    tbl[3]  = '{4'b0000, 4'b1111, 3, 0, 1};
    tbl[4]  = '{4'b0000, 4'b0101, 0, 0, 1};
    tbl[5]  = '{4'b0000, 4'b0101, 2, 0, 1};
    tbl[6]  = '{4'b0000, 4'b0101, 0, 0, 1};
    tbl[7]  = '{4'b1000, 4'b0000, 3, 1, 0};
    tbl[8]  = '{4'b0010, 4'b0100, 1, 1, 0};
    tbl[9]  = '{4'b0010, 4'b0100, 2, 0, 1};
    tbl[10] = '{4'b0001, 4'b0001, 0, 1, 0};
    tbl[11] = '{4'b0000, 4'b1000, 3, 0, 1};

    // reset with requests and a stray read beat present
    rst_n = 1'b0;
    s_if.read = '0; s_if.write = '1; s_if.byteenable = '1; s_if.writedata = '0;
    m_if.waitrequest = 1'b0; m_if.readdatavalid = 1'b1; m_if.readdata = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 4; i++) begin
      set_ch(i, 32'h1000 + 32'(i*16), 11'd1);
      s_if.writedata[i*64 +: 64] = 64'hA0 + 64'(i);
    end
    tick(); tick();
    @(negedge clk);
    chk("rst_m_read", m_if.read, 0);
    chk("rst_m_write", m_if.write, 0);
    chk("rst_s_waitreq", s_if.waitrequest, 4'b1111);
    chk("rst_s_rdvalid", s_if.readdatavalid, 4'b0000);
    tick();
    rst_n = 1'b1; s_if.write = '0; m_if.readdatavalid = 1'b0;
    tick();

    // table: one single-beat command per vector, grant checked in CMD
    for (int k = 0; k < 12; k++) begin
      s_if.read = tbl[k].rd; s_if.write = tbl[k].wr;
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_m_read", k), m_if.read, tbl[k].exp_rd);
      chk($sformatf("v%0d_m_write", k), m_if.write, tbl[k].exp_wr);
      chk($sformatf("v%0d_waitreq", k), s_if.waitrequest, wr_mask(tbl[k].g));
      chk($sformatf("v%0d_addr", k), m_if.address, 32'h1000 + 32'(tbl[k].g*16));
      if (tbl[k].exp_wr) chk($sformatf("v%0d_wdata", k), m_if.writedata, 64'hA0 + 64'(tbl[k].g));
      tick();
    end
    s_if.read = '0; s_if.write = '0;

    // drain the three table reads: ch3, ch1, ch0
    rexp[0] = 4'b1000; rexp[1] = 4'b0010; rexp[2] = 4'b0001;
    m_if.readdatavalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_if.readdata = 64'hD000 + 64'(k);
      @(negedge clk);
      chk($sformatf("drain%0d_rdv", k), s_if.readdatavalid, rexp[k]);
      chk($sformatf("drain%0d_rdata", k), s_if.readdata, 64'hD000 + 64'(k));
      tick();
    end
    @(negedge clk);
    chk("drain_empty_rdv", s_if.readdatavalid, 4'b0000);
    tick();
    m_if.readdatavalid = 1'b0;

    // single read: ch2, addr 0x100, burst 4, one gap in the return
    set_ch(2, 32'h100, 11'd4); s_if.read[2] = 1'b1;
    tick();
    @(negedge clk);
    chk("rd2_m_read", m_if.read, 1);
    chk("rd2_addr", m_if.address, 32'h100);
    chk("rd2_bc", m_if.burstcount, 11'd4);
    chk("rd2_waitreq", s_if.waitrequest, 4'b1011);
    tick();
    s_if.read[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      m_if.readdatavalid = (k != 2);
      @(negedge clk);
      chk($sformatf("rd2_beat%0d", k), s_if.readdatavalid, (k != 2) ? 4'b0100 : 4'b0000);
      tick();
    end
    m_if.readdatavalid = 1'b0;

    // ch3 read bl=2 then ch0 read bl=3 -> routing 3,3,0,0,0
    set_ch(3, 32'h300, 11'd2); set_ch(0, 32'h0, 11'd3);
    s_if.read[3] = 1'b1; s_if.read[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("ooc_g3", s_if.waitrequest, 4'b0111);
    tick();
    s_if.read[3] = 1'b0;
    tick();
    @(negedge clk);
    chk("ooc_g0", s_if.waitrequest, 4'b1110);
    tick();
    s_if.read[0] = 1'b0;
    rexp[0] = 4'b1000; rexp[1] = 4'b1000; rexp[2] = 4'b0001; rexp[3] = 4'b0001; rexp[4] = 4'b0001;
    m_if.readdatavalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("ooc_beat%0d", k), s_if.readdatavalid, rexp[k]);
      tick();
    end
    @(negedge clk);
    chk("ooc_empty", s_if.readdatavalid, 4'b0000);
    tick();
    m_if.readdatavalid = 1'b0;

    // burst lock: ch1 write bc=8 with toggling waitrequest, ch0 also requesting
    set_ch(1, 32'h200, 11'd8); set_ch(0, 32'h1000, 11'd1);
    s_if.write[1] = 1'b1; s_if.write[0] = 1'b1;
    beats = 0; bad = 0; early = 0; c = 0;
    while (c < 60 && beats < 8) begin
      m_if.waitrequest = c[0];
      @(negedge clk);
      if (m_if.write && !s_if.waitrequest[1]) begin
        if (m_if.address != 32'h200 || m_if.burstcount != 11'd8) bad++;
        if (!m_if.waitrequest) beats++;
      end
      if (!s_if.waitrequest[0]) early++;
      tick();
      // channel drops address/burstcount after the first beat
      if (beats >= 1) set_ch(1, 32'hDEAD0, 11'd1);
      c++;
    end
    s_if.write[1] = 1'b0; m_if.waitrequest = 1'b0;
    chk("burst_beats", beats, 8);
    chk("burst_addr_hold", bad, 0);
    chk("burst_ch0_locked_out", early, 0);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (m_if.write && !s_if.waitrequest[0]) found = 1'b1;
      tick();
    end
    chk("burst_then_ch0", found, 1);

    // fairness: all four channels stream single writes
    for (int i = 0; i < 4; i++) set_ch(i, 32'h1000 + 32'(i*16), 11'd1);
    fexp = '{1, 2, 3, 0, 1, 2, 3, 0};
    s_if.write = 4'b1111;
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      @(negedge clk);
      if (m_if.write) begin
        g = gnt_of(s_if.waitrequest);
        chk($sformatf("fair_grant%0d", n), g, fexp[n]);
        n++;
      end
      tick();
    end
    s_if.write = '0;
    chk("fair_count", n, 8);

    // FIFO full: eight single reads from ch0, nothing returned
    s_if.read[0] = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      @(negedge clk);
      if (m_if.read && !s_if.waitrequest[0]) n++;
      tick();
      if (n == 8) s_if.read[0] = 1'b0;
    end
    s_if.read[0] = 1'b0;
    chk("full_reads", n, 8);
    s_if.read[1] = 1'b1; s_if.write[2] = 1'b1;
    tick();
    @(negedge clk);
    chk("full_wr_granted", s_if.waitrequest, 4'b1011);
    chk("full_wr_m_write", m_if.write, 1);
    chk("full_wr_m_read", m_if.read, 0);
    tick();
    s_if.write[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("full_rd_held%0d", k), {m_if.read, s_if.waitrequest}, 5'b01111);
      tick();
    end
    m_if.readdatavalid = 1'b1;
    @(negedge clk);
    chk("full_pop_rdv", s_if.readdatavalid, 4'b0001);
    tick();
    m_if.readdatavalid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      @(negedge clk);
      if (m_if.read && !s_if.waitrequest[1]) found = 1'b1;
      tick();
    end
    s_if.read[1] = 1'b0;
    chk("full_ninth_read", found, 1);

    // reset during beat 3 of an 8-beat ch1 burst
    set_ch(1, 32'h200, 11'd8); s_if.write[1] = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstb_m_write", m_if.write, 0);
    chk("rstb_waitreq", s_if.waitrequest, 4'b1111);
    tick();
    @(negedge clk);
    chk("rstb_idle", {m_if.write, m_if.read, s_if.waitrequest}, 6'b001111);
    tick();
    rst_n = 1'b1;
    set_ch(1, 32'h1010, 11'd1);
    s_if.write = 4'b1011; m_if.readdatavalid = 1'b1;
    @(negedge clk);
    chk("rstb_late_beat", s_if.readdatavalid, 4'b0000);
    tick();
    m_if.readdatavalid = 1'b0;
    @(negedge clk);
    chk("rstb_first_grant", s_if.waitrequest, 4'b1110);
    chk("rstb_first_addr", m_if.address, 32'h1000);
    tick();
    s_if.write = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
